// File: rtl/jesd204_up_link_sequencer.sv
// JESD204 link bring-up sequencer on the up_* register bus.
// Disables the link, programs CONF0, re-enables it, then polls the link
// status until it reports DATA. A poll that runs out of time triggers a
// retry from the disable step, up to MAX_RETRIES times. Only one bus
// transaction is ever outstanding, and acks are honoured only while one is.
module jesd204_up_link_sequencer #(
  parameter logic [11:0] ADDR_LINK_DISABLE = 12'h0c0,
  parameter logic [11:0] ADDR_LINK_CONF0   = 12'h084,
  parameter logic [11:0] ADDR_LINK_STATUS  = 12'h0a0,
  parameter int          POLL_TIMEOUT      = 1024,
  parameter int          MAX_RETRIES       = 3
) (
  input  logic        up_clk,
  input  logic        up_reset,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  cfg_octets_per_multiframe,
  input  logic [7:0]  cfg_octets_per_frame,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [3:0]  retry_cnt,
  output logic        up_wreq,
  output logic [11:0] up_waddr,
  output logic [31:0] up_wdata,
  input  logic        up_wack,
  output logic        up_rreq,
  output logic [11:0] up_raddr,
  input  logic [31:0] up_rdata,
  input  logic        up_rack
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DIS   = 3'd1;
  localparam logic [2:0] S_CONF  = 3'd2;
  localparam logic [2:0] S_EN    = 3'd3;
  localparam logic [2:0] S_RD    = 3'd4;
  localparam logic [2:0] S_RWAIT = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;

  localparam logic [15:0] TIMEOUT_LOAD = 16'(POLL_TIMEOUT);
  localparam logic [3:0]  RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic [2:0]  state, nxt_state;
  logic        pend;        // a request has been issued and not yet acked
  logic        abort_pend;
  logic [15:0] timer;
  logic [9:0]  cfg_mf;
  logic [7:0]  cfg_f;

  logic        accept, wr_go, rd_go, load_timer;
  logic        set_done, set_fail, inc_retry;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack, rd_ack, abort_any, active;
  logic [31:0] conf_word;
  logic        rdata_unused;

  // Only the two link-state bits of the status word carry meaning here.
  assign rdata_unused = ^up_rdata[31:2];

  assign busy      = (state != S_IDLE);
  assign active    = (state == S_DIS) || (state == S_CONF) || (state == S_EN) ||
                     (state == S_RD)  || (state == S_RWAIT);
  assign abort_any = abort_pend || (abort && active);
  assign wr_ack    = pend && up_wack && ((state == S_DIS) || (state == S_CONF) ||
                                         (state == S_EN)  || (state == S_STOP));
  assign rd_ack    = pend && up_rack && ((state == S_RD) || (state == S_RWAIT));
  assign conf_word = {8'h00, cfg_f - 8'd1, 6'h00, cfg_mf - 10'd1};

  // Next-state decode and the request to launch on the transition edge.
  always_comb begin
    nxt_state  = state;
    accept     = 1'b0;
    wr_go      = 1'b0;
    rd_go      = 1'b0;
    wr_addr    = ADDR_LINK_DISABLE;
    wr_data    = 32'h0000_0001;
    load_timer = 1'b0;
    set_done   = 1'b0;
    set_fail   = 1'b0;
    inc_retry  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          wr_go     = 1'b1;
          nxt_state = S_DIS;
        end
      end
      S_DIS: begin
        if (wr_ack) begin
          wr_go = 1'b1;
          if (abort_any) begin
            set_fail  = 1'b1;
            nxt_state = S_STOP;
          end else begin
            wr_addr   = ADDR_LINK_CONF0;
            wr_data   = conf_word;
            nxt_state = S_CONF;
          end
        end
      end
      S_CONF: begin
        if (wr_ack) begin
          wr_go = 1'b1;
          if (abort_any) begin
            set_fail  = 1'b1;
            nxt_state = S_STOP;
          end else begin
            wr_data   = 32'h0000_0000;
            nxt_state = S_EN;
          end
        end
      end
      S_EN: begin
        if (wr_ack) begin
          if (abort_any) begin
            wr_go     = 1'b1;
            set_fail  = 1'b1;
            nxt_state = S_STOP;
          end else begin
            rd_go      = 1'b1;
            load_timer = 1'b1;
            nxt_state  = S_RD;
          end
        end
      end
      S_RD, S_RWAIT: begin
        if (rd_ack) begin
          if (abort_any) begin
            wr_go     = 1'b1;
            set_fail  = 1'b1;
            nxt_state = S_STOP;
          end else if (up_rdata[1:0] == 2'b11) begin
            set_done  = 1'b1;
            nxt_state = S_IDLE;
          end else if (timer != 16'd0) begin
            rd_go     = 1'b1;
            nxt_state = S_RD;
          end else if (retry_cnt < RETRY_LIMIT) begin
            wr_go     = 1'b1;
            inc_retry = 1'b1;
            nxt_state = S_DIS;
          end else begin
            wr_go     = 1'b1;
            set_fail  = 1'b1;
            nxt_state = S_STOP;
          end
        end else if (state == S_RD) begin
          nxt_state = S_RWAIT;
        end
      end
      S_STOP: begin
        if (wr_ack) nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Control state, status flags, poll timer and bus request registers.
  always_ff @(posedge up_clk) begin
    if (up_reset) begin
      state      <= S_IDLE;
      pend       <= 1'b0;
      abort_pend <= 1'b0;
      timer      <= 16'd0;
      retry_cnt  <= 4'd0;
      done       <= 1'b0;
      fail       <= 1'b0;
      up_wreq    <= 1'b0;
      up_rreq    <= 1'b0;
      up_waddr   <= 12'h000;
      up_wdata   <= 32'h0000_0000;
      up_raddr   <= 12'h000;
    end else begin
      state   <= nxt_state;
      up_wreq <= wr_go;
      up_rreq <= rd_go;
      if (wr_go || rd_go)        pend <= 1'b1;
      else if (wr_ack || rd_ack) pend <= 1'b0;
      if (nxt_state == S_STOP || nxt_state == S_IDLE) abort_pend <= 1'b0;
      else if (abort && active)                       abort_pend <= 1'b1;
      if (load_timer)                                          timer <= TIMEOUT_LOAD;
      else if ((state == S_RD || state == S_RWAIT) && timer != 16'd0) timer <= timer - 16'd1;
      if (accept)         retry_cnt <= 4'd0;
      else if (inc_retry) retry_cnt <= retry_cnt + 4'd1;
      if (accept)        done <= 1'b0;
      else if (set_done) done <= 1'b1;
      if (accept)        fail <= 1'b0;
      else if (set_fail) fail <= 1'b1;
      if (wr_go) begin
        up_waddr <= wr_addr;
        up_wdata <= wr_data;
      end
      if (rd_go) up_raddr <= ADDR_LINK_STATUS;
    end
  end

  // Link configuration captured when a start is accepted.
  always_ff @(posedge up_clk) begin
    if (accept) begin
      cfg_mf <= cfg_octets_per_multiframe;
      cfg_f  <= cfg_octets_per_frame;
    end
  end

endmodule

// File: tb/tb_jesd204_up_link_sequencer.sv
// Bench for jesd204_up_link_sequencer: register-bus responder, write
// scoreboard and bus-protocol monitor, with one task per scenario.
module tb_jesd204_up_link_sequencer;

  localparam int POLL = 8;
  localparam int MAXR = 2;

  logic        clk = 1'b0;
  logic        up_reset, start, abort;
  logic [9:0]  cfg_mf;
  logic [7:0]  cfg_f;
  logic        busy, done, fail;
  logic [3:0]  retry_cnt;
  logic        up_wreq, up_rreq, up_wack, up_rack, rsp_rack, stray_rack;
  logic [11:0] up_waddr, up_raddr;
  logic [31:0] up_wdata, up_rdata;

  assign up_rack = rsp_rack | stray_rack;

  jesd204_up_link_sequencer #(.POLL_TIMEOUT(POLL), .MAX_RETRIES(MAXR)) dut (
    .up_clk(clk), .up_reset(up_reset), .start(start), .abort(abort),
    .cfg_octets_per_multiframe(cfg_mf), .cfg_octets_per_frame(cfg_f),
    .busy(busy), .done(done), .fail(fail), .retry_cnt(retry_cnt),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [43:0] exp_q[$];
  int wcnt = 0, rcnt = 0, rd_delay = 1, rd_idx = 0, nreads = 0, data_on_read = 0;
  bit slow_conf = 0, outstanding = 0, prev_wreq = 0, prev_rreq = 0;

  // One clock: DUT samples at posedge; monitor and responder act at negedge.
  task automatic tick();
    logic [43:0] e;
    @(posedge clk);
    @(negedge clk);
    if (up_wreq || up_rreq) begin
      checks++;
      if (up_wreq && up_rreq) begin
        errors++; $display("FAIL req_overlap wreq=%b rreq=%b required not both", up_wreq, up_rreq);
      end
      checks++;
      if (outstanding) begin
        errors++; $display("FAIL req_while_outstanding got=1 required=0");
      end
      checks++;
      if ((up_wreq && prev_wreq) || (up_rreq && prev_rreq)) begin
        errors++; $display("FAIL req_pulse_width got=multi-cycle required=1 cycle");
      end
    end
    if (up_wreq) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_write got=%h:%h required=none", up_waddr, up_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({up_waddr, up_wdata} !== e) begin
          errors++; $display("FAIL write got=%h:%h required=%h:%h", up_waddr, up_wdata, e[43:32], e[31:0]);
        end
      end
    end
    if (up_rreq) begin
      nreads++;
      checks++;
      if (up_raddr !== 12'h0a0) begin
        errors++; $display("FAIL read_addr got=%h required=0a0", up_raddr);
      end
    end
    prev_wreq = up_wreq;
    prev_rreq = up_rreq;
    up_wack  = 1'b0;
    rsp_rack = 1'b0;
    if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) begin up_wack = 1'b1; outstanding = 0; end
    end
    if (rcnt > 0) begin
      rcnt--;
      if (rcnt == 0) begin
        rsp_rack = 1'b1; outstanding = 0; rd_idx++;
        up_rdata = (rd_idx == data_on_read) ? 32'h0000_0003 : 32'hFFFF_FFF2;
      end
    end
    if (up_wreq) begin
      wcnt = (slow_conf && up_waddr == 12'h084) ? 5 : 1;
      outstanding = 1;
    end
    if (up_rreq) begin
      rcnt = rd_delay;
      outstanding = 1;
    end
  endtask

  task automatic push_enable(input logic [9:0] mf, input logic [7:0] f);
    logic [31:0] cw;
    cw = {8'h00, f - 8'd1, 6'h00, mf - 10'd1};
    exp_q.push_back({12'h0c0, 32'h1});
    exp_q.push_back({12'h084, cw});
    exp_q.push_back({12'h0c0, 32'h0});
  endtask

  // Pulse start and confirm the first write appears one cycle later.
  task automatic do_start(input logic [9:0] mf, input logic [7:0] f);
    cfg_mf = mf; cfg_f = f; start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (up_wreq !== 1'b1 || busy !== 1'b1 || up_waddr !== 12'h0c0) begin
      errors++; $display("FAIL start_latency wreq=%b busy=%b addr=%h required 1,1,0c0", up_wreq, busy, up_waddr);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_timeout busy=%b required=0 after %0d cycles", busy, n);
    end
  endtask

  task automatic check_flags(input string name, input logic d, input logic fl, input logic [3:0] rc);
    checks++;
    if (done !== d || fail !== fl || retry_cnt !== rc || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s done=%b fail=%b retry=%0d pending_writes=%0d required done=%b fail=%b retry=%0d pending_writes=0",
               name, done, fail, retry_cnt, exp_q.size(), d, fl, rc);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({busy, done, fail, up_wreq, up_rreq} !== 5'b0 || retry_cnt !== 4'd0 ||
        up_waddr !== 12'h0 || up_wdata !== 32'h0 || up_raddr !== 12'h0) begin
      errors++;
      $display("FAIL %s busy=%b done=%b fail=%b wreq=%b rreq=%b retry=%0d waddr=%h wdata=%h raddr=%h required all 0",
               name, busy, done, fail, up_wreq, up_rreq, retry_cnt, up_waddr, up_wdata, up_raddr);
    end
  endtask

  task automatic test_reset();
    up_reset = 1'b1; start = 1'b0; abort = 1'b0; stray_rack = 1'b0;
    up_wack = 1'b0; rsp_rack = 1'b0; up_rdata = 32'h0; cfg_mf = 10'd1; cfg_f = 8'd1;
    tick(); tick();
    check_zero("reset_state");
    up_reset = 1'b0;
    tick();
    check_zero("after_reset_idle");
  endtask

  task automatic test_link_up();
    data_on_read = 3; rd_idx = 0; nreads = 0;
    push_enable(10'd32, 8'd2);
    do_start(10'd32, 8'd2);
    wait_idle();
    check_flags("link_up", 1'b1, 1'b0, 4'd0);
    checks++;
    if (nreads != 3) begin
      errors++; $display("FAIL link_up_reads got=%0d required=3", nreads);
    end
  endtask

  task automatic test_retries();
    data_on_read = 0; rd_idx = 0;
    for (int i = 0; i <= MAXR; i++) push_enable(10'd64, 8'd4);
    exp_q.push_back({12'h0c0, 32'h1});
    do_start(10'd64, 8'd4);
    wait_idle();
    check_flags("retries", 1'b0, 1'b1, 4'(MAXR));
  endtask

  task automatic test_abort();
    int n;
    slow_conf = 1; data_on_read = 0;
    exp_q.push_back({12'h0c0, 32'h1});
    exp_q.push_back({12'h084, 32'h0003_0013});
    exp_q.push_back({12'h0c0, 32'h1});
    do_start(10'd20, 8'd4);
    n = 0;
    while (!(up_wreq && up_waddr == 12'h084) && n < 50) begin tick(); n++; end
    checks++;
    if (!(up_wreq && up_waddr == 12'h084)) begin
      errors++; $display("FAIL abort_conf_seen got=absent required=CONF write");
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle();
    check_flags("abort", 1'b0, 1'b1, 4'd0);
    slow_conf = 0;
  endtask

  task automatic test_ignored();
    data_on_read = 3; rd_idx = 0; nreads = 0;
    push_enable(10'd16, 8'd1);
    do_start(10'd16, 8'd1);
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle();
    check_flags("second_start_ignored", 1'b1, 1'b0, 4'd0);
    stray_rack = 1'b1;
    tick();
    stray_rack = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || up_wreq !== 1'b0 || up_rreq !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL stray_rack busy=%b wreq=%b rreq=%b done=%b required 0,0,0,1", busy, up_wreq, up_rreq, done);
    end
    data_on_read = 1; rd_idx = 0; nreads = 0;
    push_enable(10'd8, 8'd8);
    abort = 1'b1;
    do_start(10'd8, 8'd8);
    wait_idle();
    check_flags("start_beats_abort", 1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_reset_mid_run();
    int n;
    rd_delay = 4; data_on_read = 0; rd_idx = 0;
    push_enable(10'd32, 8'd2);
    do_start(10'd32, 8'd2);
    n = 0;
    while (!up_rreq && n < 50) begin tick(); n++; end
    tick();
    up_reset = 1'b1;
    tick();
    check_zero("reset_mid_run");
    up_reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL stale_ack busy=%b done=%b fail=%b required 0,0,0", busy, done, fail);
    end
    outstanding = 0; rd_delay = 1; data_on_read = 2; rd_idx = 0; nreads = 0;
    push_enable(10'd32, 8'd2);
    do_start(10'd32, 8'd2);
    wait_idle();
    check_flags("run_after_reset", 1'b1, 1'b0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_link_up();
    test_retries();
    test_abort();
    test_ignored();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/jesd204_up_link_sequencer.md
JESD204_UP_LINK_SEQUENCER -- requirements
Module: jesd204_up_link_sequencer

Interface
REQ-001 Parameter ADDR_LINK_DISABLE, default 12'h0c0, word address of the link disable register.
REQ-002 Parameter ADDR_LINK_CONF0, default 12'h084, word address of the link configuration register.
REQ-003 Parameter ADDR_LINK_STATUS, default 12'h0a0, word address of the link status register; bits [1:0] hold the link state, 2'b11 = DATA.
REQ-004 Parameter POLL_TIMEOUT, default 1024, number of up_clk cycles allowed for the link to reach DATA; legal range 2..65535.
REQ-005 Parameter MAX_RETRIES, default 3, number of re-attempts after a timeout; legal range 0..15.
REQ-006 up_clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-007 up_reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle request to begin link bring-up.
REQ-009 abort  in  1  single-cycle request to stop the sequence and disable the link.
REQ-010 cfg_octets_per_multiframe  in  10  octets per multiframe (K*F); must be >= 1; sampled at accepted start.
REQ-011 cfg_octets_per_frame  in  8  octets per frame (F); must be >= 1; sampled at accepted start.
REQ-012 busy  out  1  high from the cycle after start is accepted until the return to IDLE.
REQ-013 done  out  1  sticky: link reached DATA; cleared by the next accepted start.
REQ-014 fail  out  1  sticky: retries exhausted or aborted; cleared by the next accepted start.
REQ-015 retry_cnt  out  4  number of timeouts taken in the current run.
REQ-016 up_wreq/up_waddr[11:0]/up_wdata[31:0]  out  register write request; up_wack  in  1  write acknowledge.
REQ-017 up_rreq/up_raddr[11:0]  out  register read request; up_rdata[31:0]  in; up_rack  in  1  read acknowledge.

Function
REQ-018 The FSM SHALL have the states IDLE, DIS, CONF, EN, RD, RWAIT, and STOP.
REQ-019 Requests: up_wreq and up_rreq are one-cycle pulses, at most one transaction is outstanding, and the next request is issued no earlier than the cycle after the ack.
REQ-020 Address and data outputs hold their values from the request cycle until the ack.
REQ-021 IDLE: start accepted only in IDLE; it latches cfg, clears done/fail/retry_cnt, and moves to DIS; start outside IDLE is ignored.
REQ-022 DIS: write ADDR_LINK_DISABLE with 32'h1; on wack, go to CONF.
REQ-023 CONF: write ADDR_LINK_CONF0 with [9:0] = octets_per_multiframe-1 and [23:16] = octets_per_frame-1, all other bits 0; on wack, go to EN.
REQ-024 EN: write ADDR_LINK_DISABLE with 32'h0; on wack, load the 16-bit timeout counter with POLL_TIMEOUT and go to RD.
REQ-025 Timeout counter: decrements every cycle in RD and RWAIT, saturates at 0, and is never reloaded during polling.
REQ-026 RD: issue a read of ADDR_LINK_STATUS, then go to RWAIT.
REQ-027 RWAIT on rack: if up_rdata[1:0] = 2'b11, set done and go to IDLE.
REQ-028 RWAIT on rack, not DATA and counter > 0: go to RD (back-to-back polling).
REQ-029 RWAIT on rack, not DATA and counter = 0: if retry_cnt < MAX_RETRIES, increment retry_cnt and go to DIS; otherwise set fail and go to STOP.
REQ-030 A DATA status on the same rack as counter expiry SHALL count as success.
REQ-031 STOP: write ADDR_LINK_DISABLE with 32'h1; on wack, go to IDLE.
REQ-032 abort in DIS, CONF, EN, RD, or RWAIT: latch a pending-abort flag.
REQ-033 Pending abort: after the outstanding ack, or immediately if none is outstanding, set fail and go to STOP; abort in IDLE or STOP is ignored.
REQ-034 start and abort in the same IDLE cycle: start wins.
REQ-035 up_wack and up_rack received when no request is outstanding are ignored.
REQ-036 Latency: start to first up_wreq is 1 cycle; wack to the next request is 1 cycle.

Reset
REQ-037 On up_reset the FSM goes to IDLE.
REQ-038 On up_reset, busy, done, fail, up_wreq, and up_rreq are 0.
REQ-039 On up_reset, retry_cnt, the timeout counter, the pending-abort flag, up_waddr, up_wdata, and up_raddr are 0.
REQ-040 up_reset mid-transaction discards any ack still in flight.

Verification
REQ-041 Link up: K*F = 32, F = 2, status DATA on the 3rd read -> writes 0x0c0=1, 0x084=0x0001001F, 0x0c0=0; 3 reads; done=1, fail=0, retry_cnt=0.
REQ-042 Retries: POLL_TIMEOUT = 8, MAX_RETRIES = 2, status never DATA -> 3 enable cycles; retry_cnt=2; final write 0x0c0=1; fail=1, busy=0.
REQ-043 Abort: abort raised while a CONF write awaits wack (delayed 5 cycles) -> no new request before wack; then 0x0c0=1 written; fail=1.
REQ-044 Ignored starts: second start while busy -> ignored; stray up_rack in IDLE -> no state change.
REQ-045 Reset mid-run: up_reset asserted in RWAIT -> next cycle all outputs 0; a later start runs the full sequence normally.
REQ-046 Timing: every run -> up_wreq/up_rreq are single-cycle and never both high; start-to-first-up_wreq is exactly 1 cycle.
